// File: rtl/param_decoder_scan.sv
// param_decoder_scan: registered N-to-2^N one-hot decoder with enable, output polarity and an auto-scan mode with programmable dwell.
module param_decoder_scan #(
   parameter int SEL_W      = 3,
   parameter int DWELL_W    = 8,
   parameter int ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  sel_valid,
   input  logic [DWELL_W-1:0]    dwell,
   output logic [(2**SEL_W)-1:0] y,
   output logic [SEL_W-1:0]      idx,
   output logic                  active,
   output logic                  wrap
);
   localparam int OUT_W = 2**SEL_W;
   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
   state_t             state_q, state_d;
   logic [OUT_W-1:0]   y_q, y_d;
   logic [SEL_W-1:0]   idx_q, idx_d, idx_inc;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic               active_q, active_d, wrap_q, wrap_d;
   always_comb begin
      idx_inc  = idx_q + 1'b1;
      state_d  = !en ? IDLE : (mode ? SCAN : DIRECT);
      y_d      = y_q;
      idx_d    = idx_q;
      active_d = active_q;
      wrap_d   = 1'b0;
      cnt_d    = '0;
      if (!en) begin
         y_d      = '0;
         active_d = 1'b0;
      end else if (!mode) begin
         if (sel_valid) begin
            y_d      = OUT_W'(1) << sel;
            idx_d    = sel;
            active_d = 1'b1;
         end
      end else if (state_q != SCAN) begin
         y_d      = OUT_W'(1);
         idx_d    = '0;
         active_d = 1'b1;
         cnt_d    = dwell;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         y_d    = OUT_W'(1) << idx_inc;
         idx_d  = idx_inc;
         cnt_d  = dwell;
         wrap_d = &idx_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         y_q      <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         y_q      <= y_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         wrap_q   <= wrap_d;
      end
   end
   assign y      = (ACTIVE_LOW != 0) ? ~y_q : y_q;
   assign idx    = idx_q;
   assign active = active_q;
   assign wrap   = wrap_q;
endmodule

// File: tb/tb_param_decoder_scan.sv
// tb_param_decoder_scan: vector table, directed scan sequences and random stimulus against a timestamp-based reference model.
module tb_param_decoder_scan;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1, mode = 1'b1, sv = 1'b0;
   logic [2:0] sel = '0;
   logic [7:0] dwell = '0;
   logic [7:0] y;
   logic [2:0] idx;
   logic       active, wrap;
   logic       en2 = 1'b0, mode2 = 1'b0, sv2 = 1'b0;
   logic [1:0] sel2 = '0;
   logic [3:0] y2;
   logic [1:0] idx2;
   logic       active2, wrap2;
   int         n_pass = 0, n_total = 0;
   int         m_st = 0, m_line = 0;
   bit         m_on = 0, m_wrap = 0;
   longint     cyc = 0, next_step = 0;

   param_decoder_scan dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .sel_valid(sv),
      .dwell(dwell), .y(y), .idx(idx), .active(active), .wrap(wrap)
   );
   param_decoder_scan #(.SEL_W(2), .ACTIVE_LOW(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel(sel2), .sel_valid(sv2),
      .dwell(8'd0), .y(y2), .idx(idx2), .active(active2), .wrap(wrap2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en, mode;
      logic [2:0] sel;
      logic       sv;
      logic [7:0] ey;
      logic [2:0] eidx;
      logic       eact;
   } vec_t;
   vec_t vt[14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Line changes are scheduled as absolute cycle numbers rather than a down-counter.
   task automatic model();
      cyc++;
      m_wrap = 0;
      if (!en) begin
         m_st = 0;
         m_on = 0;
      end else if (!mode) begin
         m_st = 1;
         if (sv) begin
            m_line = int'(sel);
            m_on = 1;
         end
      end else if (m_st != 2) begin
         m_st = 2;
         m_line = 0;
         m_on = 1;
         next_step = cyc + longint'(dwell) + 1;
      end else if (cyc == next_step) begin
         m_line = (m_line + 1) % 8;
         m_wrap = (m_line == 0);
         next_step = cyc + longint'(dwell) + 1;
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_line = 0; m_on = 0; m_wrap = 0;
   endtask

   task automatic step();
      @(posedge clk);
      model();
      #1;
      check("model_y", y, m_on ? (32'd1 << m_line) : 32'd0);
      check("model_idx", idx, m_line);
      check("model_active", active, m_on);
      check("model_wrap", wrap, m_wrap);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_y", y, 8'h00);
      check("rst_idx", idx, 0);
      check("rst_active", active, 0);
      check("rst_wrap", wrap, 0);
      check("rst_y2", y2, 4'hf);
      @(negedge clk) rst_n = 1'b1;
      step();
      check("post_rst_y", y, 8'h01);

      for (int i = 0; i < 8; i++) vt[i] = '{1, 0, 3'(i), 1, 8'(1 << i), 3'(i), 1};
      vt[8]  = '{1, 0, 3'd3, 0, 8'h80, 3'd7, 1};
      vt[9]  = '{1, 0, 3'd5, 0, 8'h80, 3'd7, 1};
      vt[10] = '{0, 0, 3'd5, 1, 8'h00, 3'd7, 0};
      vt[11] = '{1, 0, 3'd6, 0, 8'h00, 3'd7, 0};
      vt[12] = '{1, 0, 3'd2, 1, 8'h04, 3'd2, 1};
      vt[13] = '{1, 0, 3'd2, 0, 8'h04, 3'd2, 1};
      for (int i = 0; i < 14; i++) begin
         en = vt[i].en; mode = vt[i].mode; sel = vt[i].sel; sv = vt[i].sv;
         step();
         check($sformatf("vec%0d_y", i), y, vt[i].ey);
         check($sformatf("vec%0d_idx", i), idx, vt[i].eidx);
         check($sformatf("vec%0d_active", i), active, vt[i].eact);
      end

      sv = 0; mode = 1; dwell = 0;
      step();
      check("scan0_entry_y", y, 8'h01);
      check("scan0_entry_wrap", wrap, 0);
      for (int k = 1; k <= 24; k++) begin
         step();
         check($sformatf("scan0_idx_k%0d", k), idx, k % 8);
         check($sformatf("scan0_wrap_k%0d", k), wrap, (k % 8) == 0);
      end

      en = 0;
      step();
      en = 1; dwell = 2;
      step();
      check("scan2_entry_idx", idx, 0);
      for (int k = 1; k <= 39; k++) begin
         step();
         check($sformatf("scan2_idx_k%0d", k), idx, (k <= 35) ? (k / 3) % 8 : 3 + (k - 35));
         check($sformatf("scan2_wrap_k%0d", k), wrap, k == 24);
         if (k == 34) dwell = 0;
      end

      for (int k = 0; k < 20 && m_line != 4; k++) step();
      check("reach_idx4", idx, 4);
      mode = 0; sv = 0; sel = 6;
      for (int k = 0; k < 3; k++) begin
         step();
         check("scan_to_direct_hold", y, 8'h10);
      end
      sv = 1; sel = 1;
      step();
      check("direct_after_scan", y, 8'h02);

      sv = 0; mode = 1;
      for (int k = 0; k < 20 && !(m_st == 2 && m_line == 6); k++) step();
      check("reach_idx6", idx, 6);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_y", y, 8'h00);
      check("async_rst_idx", idx, 0);
      check("async_rst_active", active, 0);
      @(negedge clk) rst_n = 1'b1;
      step();
      check("after_async_y", y, 8'h01);

      for (int i = 0; i < 400; i++) begin
         en = ($urandom % 10) != 0;
         if ($urandom % 8 == 0) mode = ~mode;
         sel = 3'($urandom);
         sv = 1'($urandom);
         dwell = 8'($urandom_range(0, 3));
         step();
      end

      en2 = 1; mode2 = 0; sel2 = 2; sv2 = 1;
      @(posedge clk); #1;
      check("al_direct_y2", y2, 4'b1011);
      check("al_direct_idx2", idx2, 2);
      check("al_direct_active2", active2, 1);
      en2 = 0;
      @(posedge clk); #1;
      check("al_idle_y2", y2, 4'b1111);
      check("al_idle_active2", active2, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
